sar_search: RTL and testbench
=============================

SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter: WIDTH, default 4, bit width of the searched value range [0, 2^WIDTH-1].
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request a new search; sampled only in IDLE.
REQ-005 Port: guess  output  WIDTH  candidate value presented to the external comparator as operand a.
REQ-006 Port: guess_valid  output  1  guess is stable and awaiting a comparator result.
REQ-007 Port: cmp_valid  input  1  cmp_res is valid this cycle.
REQ-008 Port: cmp_res  input  3  one-hot result {gt,eq,lt}: 3'b100 guess>target, 3'b010 equal, 3'b001 guess<target.
REQ-009 Port: busy  output  1  high from the cycle after an accepted start until done.
REQ-010 Port: done  output  1  one-cycle pulse when the search ends.
REQ-011 Port: found  output  1  target located; valid from done until the next accepted start.
REQ-012 Port: result  output  WIDTH  located value; valid with found.
REQ-013 Port: err  output  1  illegal cmp_res code received; valid from done until the next accepted start.

Function
REQ-014 The FSM SHALL have states IDLE, ASK, CALC and FIN.
- IDLE: start=1 -> load lo=0, hi=2^WIDTH-1, clear found/err -> ASK.
- ASK: guess_valid=1; guess=lo+((hi-lo)>>1); cmp_valid=0 -> stay; cmp_valid=1 -> CALC.
- CALC: guess_valid=0; one cycle for bound update -> ASK or FIN.
- FIN: done=1 for exactly one cycle -> IDLE.
REQ-015 guess SHALL be held constant while guess_valid=1.
REQ-016 cmp_res=3'b010 in ASK SHALL set found=1 and result=guess, then go to FIN.
REQ-017 cmp_res=3'b100 SHALL set hi=guess-1, or go to FIN with found=0 when guess==lo.
REQ-018 cmp_res=3'b001 SHALL set lo=guess+1, or go to FIN with found=0 when guess==hi.
REQ-019 lo and hi SHALL be WIDTH+1 bits wide so that guess-1 and guess+1 never wrap.
REQ-020 Any cmp_res that is not one-hot (3'b000, 3'b011, 3'b111, etc.) SHALL set err=1 and found=0, then go to FIN.
REQ-021 A search SHALL take at most WIDTH+1 comparisons.
REQ-022 start SHALL be ignored in ASK, CALC and FIN; cmp_valid SHALL be ignored outside ASK.

Reset
REQ-023 With rst_n=0 at a clock edge, all of the following SHALL be 0 on the next cycle, including when reset occurs mid-search:
- state=IDLE;
- guess, guess_valid, busy, done, found, result, err;
- lo, hi.

Configuration
REQ-024 With SAR_SEARCH_ITER_CNT_EN defined, an extra output iter_cnt (clog2(WIDTH+2) bits) SHALL:
- reset and clear to 0 on start;
- increment once per accepted comparison;
- hold its value after done.
REQ-025 Without SAR_SEARCH_ITER_CNT_EN, the port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 The shared package sar_search_pkg SHALL hold:
- constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001;
- the FSM state encoding.
REQ-027 One sub-module, sar_cmp_check, SHALL decode cmp_res into is_gt, is_eq, is_lt and is_illegal; the midpoint and bound logic stay in sar_search.

Verification
REQ-028 Bench SHALL cover, with WIDTH=4, a behavioural comparator answering one cycle after guess_valid, and iter_cnt checked when the macro is enabled:
- target=11: guesses 7, 11 -> done, found=1, result=11, iter_cnt=2.
- target=0: guesses 7, 3, 1, 0 -> found=1, result=0, iter_cnt=4.
- target=15: guesses 7, 11, 13, 14, 15 -> found=1, result=15, iter_cnt=5.
- Comparator always returns 3'b001 -> guesses 7, 11, 13, 14, 15 -> done, found=0, err=0.
- First response 3'b011 -> done, err=1, found=0.
- rst_n=0 while in ASK after guess=7 -> next cycle all outputs 0 and state IDLE; a new start searching target=5 gives result=5.

Source files
------------

// File: rtl/sar_search_pkg.sv
// Shared constants and FSM encoding for the successive-approximation search block.
package sar_search_pkg;

  // One-hot comparator result codes {gt, eq, lt}
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

  // Idle must encode to zero so that a reset state reads as all-zeros
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAsk  = 2'd1,
    StCalc = 2'd2,
    StFin  = 2'd3
  } state_e;

endpackage

// File: rtl/sar_cmp_check.sv
// Decodes the one-hot comparator result into flags; anything not one-hot is illegal.
module sar_cmp_check
  import sar_search_pkg::*;
(
  input  logic [2:0] cmp_res_i,
  output logic       is_gt_o,
  output logic       is_eq_o,
  output logic       is_lt_o,
  output logic       is_illegal_o
);

  assign is_gt_o      = (cmp_res_i == CMP_GT);
  assign is_eq_o      = (cmp_res_i == CMP_EQ);
  assign is_lt_o      = (cmp_res_i == CMP_LT);
  assign is_illegal_o = !(is_gt_o || is_eq_o || is_lt_o);

endmodule

// File: rtl/sar_search.sv
// Binary search over [0, 2^WIDTH-1] driven by an external comparator.
// Optional feature: define SAR_SEARCH_ITER_CNT_EN to add the iter_cnt output.
module sar_search
  import sar_search_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] guess,
  output logic             guess_valid,
  input  logic             cmp_valid,
  input  logic [2:0]       cmp_res,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic             err
`ifdef SAR_SEARCH_ITER_CNT_EN
  ,
  output logic [$clog2(WIDTH+2)-1:0] iter_cnt
`endif
);

  // One extra bit so that mid-1 and mid+1 never wrap
  localparam int unsigned BW = WIDTH + 1;
  localparam logic [BW-1:0] MaxVal = {1'b0, {WIDTH{1'b1}}};
  localparam logic [BW-1:0] One    = BW'(1);

  state_e           state_q, state_d;
  logic [BW-1:0]    lo_q, lo_d, hi_q, hi_d;
  logic [2:0]       cmp_q, cmp_d;
  logic             found_q, found_d, err_q, err_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [BW-1:0]    mid;
  logic             is_gt, is_eq, is_lt, is_illegal;

  // Midpoint is purely a function of the bounds, so it holds steady while in ASK
  assign mid = lo_q + ((hi_q - lo_q) >> 1);

  // Decode the response captured in ASK; evaluated during CALC
  sar_cmp_check u_cmp_check (
    .cmp_res_i    (cmp_q),
    .is_gt_o      (is_gt),
    .is_eq_o      (is_eq),
    .is_lt_o      (is_lt),
    .is_illegal_o (is_illegal)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '0;
      cmp_q    <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cmp_q    <= cmp_d;
      found_q  <= found_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  // Next-state and bound update logic
  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cmp_d    = cmp_q;
    found_d  = found_q;
    err_d    = err_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = MaxVal;
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = StAsk;
        end
      end
      StAsk: begin
        if (cmp_valid) begin
          cmp_d   = cmp_res;
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (is_illegal) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = StFin;
        end else if (is_eq) begin
          found_d  = 1'b1;
          result_d = mid[WIDTH-1:0];
          state_d  = StFin;
        end else if (is_gt) begin
          // Nothing left below the guess: target absent
          if (mid == lo_q) begin
            state_d = StFin;
          end else begin
            hi_d    = mid - One;
            state_d = StAsk;
          end
        end else if (is_lt) begin
          if (mid == hi_q) begin
            state_d = StFin;
          end else begin
            lo_d    = mid + One;
            state_d = StAsk;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state and held result registers
  always_comb begin
    guess       = mid[WIDTH-1:0];
    guess_valid = (state_q == StAsk);
    busy        = (state_q != StIdle);
    done        = (state_q == StFin);
    found       = found_q;
    result      = result_q;
    err         = err_q;
  end

`ifdef SAR_SEARCH_ITER_CNT_EN
  logic [$clog2(WIDTH+2)-1:0] iter_q;

  // Counts accepted comparisons; cleared by a new search, held afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iter_q <= '0;
    end else if (state_q == StIdle && start) begin
      iter_q <= '0;
    end else if (state_q == StAsk && cmp_valid) begin
      iter_q <= iter_q + 1'b1;
    end
  end

  assign iter_cnt = iter_q;
`endif

endmodule

// File: tb/tb_sar_search.sv
// Directed self-checking bench for sar_search with WIDTH=4 and a behavioural comparator.
// Define SAR_SEARCH_ITER_CNT_EN to also check iter_cnt.
module tb_sar_search;
  import sar_search_pkg::*;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] guess;
  logic         guess_valid;
  logic         cmp_valid;
  logic [2:0]   cmp_res;
  logic         busy, done, found, err;
  logic [W-1:0] result;
`ifdef SAR_SEARCH_ITER_CNT_EN
  logic [$clog2(W+2)-1:0] iter_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sar_search #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .guess       (guess),
    .guess_valid (guess_valid),
    .cmp_valid   (cmp_valid),
    .cmp_res     (cmp_res),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .result      (result),
    .err         (err)
`ifdef SAR_SEARCH_ITER_CNT_EN
    ,
    .iter_cnt    (iter_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: honest comparator, 1: always "guess<target", 2: illegal code 3'b011
  function automatic logic [2:0] respond(input int mode, input int g, input int target);
    if (mode == 1) return 3'b001;
    if (mode == 2) return 3'b011;
    if (g > target) return 3'b100;
    if (g == target) return 3'b010;
    return 3'b001;
  endfunction

  // Caller is at a negedge. Runs one search and checks the whole outcome.
  task automatic run_search(input string name, input int mode, input int target,
                            input int eg[6], input int en, input logic exp_found,
                            input int exp_result, input logic exp_err);
    int     gq[$];
    logic   pending;
    logic   seen;
    int     held;
    pending = 1'b0;
    seen    = 1'b0;
    held    = 0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, busy, 1);
    for (int c = 0; c < 100; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (cmp_valid) begin
        cmp_valid = 1'b0;
        cmp_res   = 3'b000;
      end else if (pending) begin
        // Guess must not move while awaiting the answer
        check({name, "_guess_hold"}, guess, held);
        cmp_res   = respond(mode, held, target);
        cmp_valid = 1'b1;
        pending   = 1'b0;
      end else if (guess_valid) begin
        held = int'(guess);
        gq.push_back(held);
        pending = 1'b1;
      end
      @(negedge clk);
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_found"}, found, exp_found);
    if (exp_found) check({name, "_result"}, result, exp_result);
    check({name, "_err"}, err, exp_err);
    check({name, "_n_guesses"}, gq.size(), en);
    for (int i = 0; i < en && i < gq.size(); i++) begin
      check($sformatf("%s_guess%0d", name, i), gq[i], eg[i]);
    end
`ifdef SAR_SEARCH_ITER_CNT_EN
    check({name, "_iter_cnt"}, iter_cnt, en);
`endif
    @(negedge clk);
    check({name, "_done_pulse"}, done, 0);
    check({name, "_idle_busy"}, busy, 0);
`ifdef SAR_SEARCH_ITER_CNT_EN
    check({name, "_iter_hold"}, iter_cnt, en);
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    cmp_valid = 1'b0;
    cmp_res   = 3'b000;
    @(negedge clk);
    @(negedge clk);
    check("rst_guess", guess, 0);
    check("rst_guess_valid", guess_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_search("t11", 0, 11, '{7, 11, 0, 0, 0, 0}, 2, 1'b1, 11, 1'b0);
    run_search("t0", 0, 0, '{7, 3, 1, 0, 0, 0}, 4, 1'b1, 0, 1'b0);
    run_search("t15", 0, 15, '{7, 11, 13, 14, 15, 0}, 5, 1'b1, 15, 1'b0);
    run_search("all_lt", 1, 0, '{7, 11, 13, 14, 15, 0}, 5, 1'b0, 0, 1'b0);
    run_search("illegal", 2, 0, '{7, 0, 0, 0, 0, 0}, 1, 1'b0, 0, 1'b1);

    // Reset in the middle of a search, while ASK presents guess=7
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("mid_guess_valid", guess_valid, 1);
    check("mid_guess", guess, 7);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_state", dut.state_q, StIdle);
    check("mrst_guess", guess, 0);
    check("mrst_guess_valid", guess_valid, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_found", found, 0);
    check("mrst_result", result, 0);
    check("mrst_err", err, 0);
    check("mrst_lo", dut.lo_q, 0);
    check("mrst_hi", dut.hi_q, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_search("t5", 0, 5, '{7, 3, 5, 0, 0, 0}, 3, 1'b1, 5, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
